// File: rtl/shift_pkg.sv
// shift_pkg: shared mode encoding for shift and serialiser blocks
package shift_pkg;

    typedef enum logic [2:0] {
        SH_HOLD  = 3'd0,
        SH_SHL   = 3'd1,
        SH_SHR   = 3'd2,
        SH_ROL   = 3'd3,
        SH_ROR   = 3'd4,
        SH_LOAD  = 3'd5,
        SH_CLEAR = 3'd6,
        SH_RSVD  = 3'd7
    } shift_mode_t;

    // True for every mode that moves data one position and advances the counter
    function automatic logic is_shift(input shift_mode_t m);
        return m inside {SH_SHL, SH_SHR, SH_ROL, SH_ROR};
    endfunction

    // True for modes that restart the shift counter
    function automatic logic is_restart(input shift_mode_t m);
        return m inside {SH_LOAD, SH_CLEAR};
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// shift_cnt: saturating up-counter with synchronous zero and increment enable
module shift_cnt #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Zero wins over increment; increment stops at MAX so the count never wraps
    always_comb begin
        cnt_d = clr ? '0 : (inc && cnt_q != W'(MAX)) ? cnt_q + W'(1) : cnt_q;
    end

    // Count register, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with load, shift, rotate, clear and saturating shift count
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    shift_mode_t      mode_e;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign mode_e = shift_mode_t'(mode);

    // Next register value; a low enable freezes everything, reserved mode acts as hold
    always_comb begin
        q_d = q_q;
        if (enable) begin
            case (mode_e)
                SH_SHL:   q_d = {q_q[WIDTH-2:0], serial_in_l};
                SH_SHR:   q_d = {serial_in_r, q_q[WIDTH-1:1]};
                SH_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                SH_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                SH_LOAD:  q_d = d;
                SH_CLEAR: q_d = '0;
                default:  q_d = q_q;
            endcase
        end
    end

    // Data register, cleared asynchronously by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) q_q <= '0;
        else          q_q <= q_d;
    end

    shift_cnt #(
        .MAX (WIDTH),
        .W   (CNT_W)
    ) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (enable && is_restart(mode_e)),
        .inc     (enable && is_shift(mode_e)),
        .cnt     (count)
    );

    assign q            = q_q;
    assign serial_out_l = q_q[WIDTH-1];
    assign serial_out_r = q_q[0];
    assign full         = (count == CNT_W'(WIDTH));

endmodule
